// File: rtl/guihca_pkg.sv
// rtl/guihca_pkg.sv - shared types, defaults and arbitration helper for adder_share_ctrl
package guihca_pkg;

  // Controller sequencing: wait, grant pulse, accumulate, paced display hold
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ADD   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Requester identity, used both for the current selection and the last-served pointer
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  localparam int          DEF_DATA_W    = 8;
  localparam logic [23:0] DEF_MAX_COUNT = 24'd10_000_000;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins
  function automatic src_e pick_winner(input logic a, input logic b, input src_e last);
    src_e win;
    if (a && b) begin
      win = (last == SRC_B) ? SRC_A : SRC_B;
    end else if (a) begin
      win = SRC_A;
    end else begin
      win = SRC_B;
    end
    return win;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_hold_timer.sv
// rtl/adder_share_ctrl_hold_timer.sv - display pacing counter with clear and terminal-count flag
module hold_timer
  import guihca_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  logic [23:0] count_q;
  logic [23:0] count_d;

  // Clear on start so the first cycle after start reads zero; otherwise count up.
  // The count is only meaningful while the owner is holding, so wrap is harmless.
  always_comb begin
    count_d = count_q + 24'd1;
    if (start) begin
      count_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == (MAX_COUNT - 24'd1));

endmodule

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - round-robin sharing of one add/accumulate datapath between two requesters
module adder_share_ctrl
  import guihca_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT = DEF_MAX_COUNT,
  parameter int          DATA_W    = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  input  logic              clr,
  output logic [DATA_W-1:0] acc_out,
  output logic              ovf,
  output logic              busy
);

  state_e            state_q, state_d;
  src_e              sel_q, sel_d;
  src_e              last_q, last_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W:0]   sum;
  logic              timer_start;
  logic              timer_done;

  hold_timer #(
    .MAX_COUNT(MAX_COUNT)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .start(timer_start),
    .done (timer_done)
  );

  // Next-state, arbitration and operand capture; requests are only looked at in IDLE
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    operand_d   = operand_q;
    timer_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          sel_d   = pick_winner(req_a, req_b, last_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        operand_d = (sel_q == SRC_A) ? data_a : data_b;
        last_d    = sel_q;
        state_d   = ADD;
      end
      ADD: begin
        timer_start = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (timer_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any grant or add in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= SRC_A;
      last_q    <= SRC_B;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      operand_q <= operand_d;
    end
  end

  assign sum = {1'b0, acc_q} + {1'b0, operand_q};

  // Accumulator update; clear outranks a coinciding add and drops its operand
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ADD) begin
      acc_d = sum[DATA_W-1:0];
      ovf_d = ovf_q | sum[DATA_W];
    end
  end

  // Accumulator and sticky carry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign gnt_a   = (state_q == GRANT) && (sel_q == SRC_A);
  assign gnt_b   = (state_q == GRANT) && (sel_q == SRC_B);
  assign busy    = (state_q != IDLE);
  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule
